// File: rtl/code_verify_if.sv
// Round-sequencer bus: controller/player inputs and round status outputs.
interface code_verify_if;
  logic       enable;
  logic       arm;
  logic [4:0] random;
  logic [4:0] sw;
  logic       btn_confirm;
  logic [4:0] code_show;
  logic       showing;
  logic       start;
  logic       startInput;
  logic [4:0] sec_left;
  logic [1:0] tries_left;
  logic       success;
  logic       fail;
  logic       round_done;

  modport master (
    output enable, arm, random, sw, btn_confirm,
    input  code_show, showing, start, startInput, sec_left, tries_left,
           success, fail, round_done
  );

  modport slave (
    input  enable, arm, random, sw, btn_confirm,
    output code_show, showing, start, startInput, sec_left, tries_left,
           success, fail, round_done
  );
endinterface

// File: rtl/code_verify.sv
// Round sequencer: shows the latched code, runs the timed entry window with
// limited tries, holds the win/lose face and pulses round_done at the end.
module code_verify #(
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned SHOW_SEC   = 3,
  parameter int unsigned LIMIT_SEC  = 20,
  parameter int unsigned MAX_TRIES  = 3,
  parameter int unsigned RESULT_SEC = 3
) (
  input logic         clk,
  input logic         rst_n,
  code_verify_if.slave bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SHOW, INPUT, WIN, LOSE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    sec_q, sec_d;
  logic [1:0]    tries_q, tries_d;
  logic [4:0]    code_q, code_d;
  logic          arm_q, arm_ok_q;
  logic [2:0]    sync_q;
  logic          confirm_q;

  logic [4:0]    code_show_q, code_show_d;
  logic          showing_q, showing_d;
  logic          start_q, start_d;
  logic          start_input_q, start_input_d;
  logic [4:0]    sec_left_q, sec_left_d;
  logic [1:0]    tries_left_q, tries_left_d;
  logic          success_q, success_d;
  logic          fail_q, fail_d;
  logic          round_done_q, round_done_d;

  logic tick, arm_edge, match;

  assign tick     = (presc_q == PRESC_MAX);
  // arm_ok_q masks the first cycle after reset so an arm level held across
  // reset is not mistaken for a fresh request.
  assign arm_edge = bus.enable & bus.arm & ~arm_q & arm_ok_q;
  assign match    = (bus.sw == code_q);

  always_comb begin
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + PW'(1);
    sec_d   = sec_q;
    tries_d = tries_q;
    code_d  = code_q;

    unique case (state_q)
      IDLE: begin
        presc_d = '0;
        if (arm_edge) begin
          state_d = SHOW;
          code_d  = bus.random;
          sec_d   = 5'(SHOW_SEC);
        end
      end
      SHOW: begin
        if (tick) begin
          if (sec_q <= 5'd1) begin
            state_d = INPUT;
            sec_d   = 5'(LIMIT_SEC);
            tries_d = 2'(MAX_TRIES);
          end else begin
            sec_d = sec_q - 5'd1;
          end
        end
      end
      INPUT: begin
        // A wrong confirm does not swallow a coincident tick: both counters
        // step, and either running out ends the round.
        if (confirm_q && match) begin
          state_d = WIN;
          sec_d   = 5'(RESULT_SEC);
          tries_d = '0;
        end else begin
          if (confirm_q && tries_q != '0) tries_d = tries_q - 2'd1;
          if (tick && sec_q != '0)        sec_d   = sec_q - 5'd1;
          if ((confirm_q && tries_q <= 2'd1) || (tick && sec_q <= 5'd1)) begin
            state_d = LOSE;
            sec_d   = 5'(RESULT_SEC);
            tries_d = '0;
          end
        end
      end
      WIN, LOSE: begin
        if (tick) begin
          if (sec_q <= 5'd1) begin
            state_d = IDLE;
            sec_d   = '0;
          end else begin
            sec_d = sec_q - 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) presc_d = '0;

    if (!bus.enable) begin
      state_d = IDLE;
      presc_d = '0;
      sec_d   = '0;
      tries_d = '0;
      code_d  = '0;
    end

    code_show_d   = (state_d == SHOW)  ? code_d  : '0;
    showing_d     = (state_d == SHOW);
    start_d       = (state_d == INPUT);
    start_input_d = (state_d == INPUT);
    sec_left_d    = (state_d == INPUT) ? sec_d   : '0;
    tries_left_d  = (state_d == INPUT) ? tries_d : '0;
    success_d     = (state_d == WIN);
    fail_d        = (state_d == LOSE);
    // Registered one cycle ahead so the pulse sits on the last result cycle.
    round_done_d  = ((state_d == WIN) || (state_d == LOSE)) &&
                    (presc_d == PRESC_MAX) && (sec_d <= 5'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      presc_q       <= '0;
      sec_q         <= '0;
      tries_q       <= '0;
      code_q        <= '0;
      arm_q         <= 1'b0;
      arm_ok_q      <= 1'b0;
      sync_q        <= '0;
      confirm_q     <= 1'b0;
      code_show_q   <= '0;
      showing_q     <= 1'b0;
      start_q       <= 1'b0;
      start_input_q <= 1'b0;
      sec_left_q    <= '0;
      tries_left_q  <= '0;
      success_q     <= 1'b0;
      fail_q        <= 1'b0;
      round_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      sec_q         <= sec_d;
      tries_q       <= tries_d;
      code_q        <= code_d;
      arm_q         <= bus.arm;
      arm_ok_q      <= 1'b1;
      sync_q        <= {sync_q[1:0], bus.btn_confirm};
      confirm_q     <= sync_q[1] & ~sync_q[2];
      code_show_q   <= code_show_d;
      showing_q     <= showing_d;
      start_q       <= start_d;
      start_input_q <= start_input_d;
      sec_left_q    <= sec_left_d;
      tries_left_q  <= tries_left_d;
      success_q     <= success_d;
      fail_q        <= fail_d;
      round_done_q  <= round_done_d;
    end
  end

  assign bus.code_show  = code_show_q;
  assign bus.showing    = showing_q;
  assign bus.start      = start_q;
  assign bus.startInput = start_input_q;
  assign bus.sec_left   = sec_left_q;
  assign bus.tries_left = tries_left_q;
  assign bus.success    = success_q;
  assign bus.fail       = fail_q;
  assign bus.round_done = round_done_q;

endmodule
